// File: rtl/pool_line_pair_buffer_pkg.sv
// Shared definitions for the row-pair buffer and the max-pool top.
// The state encoding and the lane packing of a pair word live here.
package pool_line_pair_buffer_pkg;

    typedef enum logic {
        StEven = 1'b0,
        StOdd  = 1'b1
    } pair_state_e;

    localparam int unsigned PixWDefault = 16;

    // Pair word layout: even row in the low half, odd row in the high half.
    localparam bit PairEvenLow = 1'b1;

endpackage

// File: rtl/pool_line_pair_buffer.sv
// Row-pair buffer feeding the 2x2 max-pool array: pairs rows (2k, 2k+1) into one wide word.
// An odd final row of a map is paired with itself so the pool stage sees an ordinary pair.
module pool_line_pair_buffer
    import pool_line_pair_buffer_pkg::*;
#(
    parameter int unsigned PIX_W = PixWDefault,
    parameter int unsigned ROW_W = 28,
    parameter int unsigned ROWS  = 28,
    localparam int unsigned LANES = ROW_W / 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic [ROW_W*PIX_W-1:0]     din_row,
    output logic                       pair_valid,
    input  logic                       pair_ready,
    output logic [2*ROW_W*PIX_W-1:0]   pair_data,
    output logic [LANES-1:0]           lane_en,
    output logic                       pair_last,
    output logic                       frame_done
);

    localparam int unsigned RowBits = ROW_W * PIX_W;
    localparam int unsigned CntW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    pair_state_e          state_q;
    logic [CntW-1:0]      row_cnt_q;
    logic [RowBits-1:0]   row0_q;

    logic in_fire;
    logic out_fire;
    logic row_last;

    function automatic logic [2*RowBits-1:0] pack_pair(input logic [RowBits-1:0] odd_row,
                                                       input logic [RowBits-1:0] even_row);
        return PairEvenLow ? {odd_row, even_row} : {even_row, odd_row};
    endfunction

    // Slot frees up in the same cycle it is consumed, giving one pair per two rows.
    assign din_ready = !pair_valid || pair_ready;
    assign in_fire   = din_valid && din_ready;
    assign out_fire  = pair_valid && pair_ready;
    assign row_last  = (row_cnt_q == CntW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEven;
            row_cnt_q  <= '0;
            row0_q     <= '0;
            pair_valid <= 1'b0;
            pair_data  <= '0;
            lane_en    <= '0;
            pair_last  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_fire && pair_last;

            if (out_fire) begin
                pair_valid <= 1'b0;
                lane_en    <= '0;
            end

            // A load in the same cycle as a consume overrides the clear above.
            if (in_fire) begin
                row_cnt_q <= row_last ? '0 : row_cnt_q + 1'b1;
                unique case (state_q)
                    StEven: begin
                        row0_q <= din_row;
                        if (row_last) begin
                            pair_data  <= pack_pair(din_row, din_row);
                            pair_last  <= 1'b1;
                            pair_valid <= 1'b1;
                            lane_en    <= '1;
                        end else begin
                            state_q <= StOdd;
                        end
                    end
                    StOdd: begin
                        pair_data  <= pack_pair(din_row, row0_q);
                        pair_last  <= row_last;
                        pair_valid <= 1'b1;
                        lane_en    <= '1;
                        state_q    <= StEven;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pool_line_pair_buffer.sv
// Scoreboard bench: instance 0 has ROWS=28, instance 1 has ROWS=5; both share clock and reset.
module tb_pool_line_pair_buffer;

    localparam int unsigned PixW    = 16;
    localparam int unsigned RowW    = 28;
    localparam int unsigned Lanes   = RowW / 2;
    localparam int unsigned RowBits = RowW * PixW;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic                   din_valid  [2];
    logic                   din_ready  [2];
    logic [RowBits-1:0]     din_row    [2];
    logic                   pair_valid [2];
    logic                   pair_ready [2];
    logic [2*RowBits-1:0]   pair_data  [2];
    logic [Lanes-1:0]       lane_en    [2];
    logic                   pair_last  [2];
    logic                   frame_done [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt [2];
    logic prev_done [2];
    bit   rand_ready_en = 1'b0;

    always #5 clk = ~clk;

    pool_line_pair_buffer #(.PIX_W(PixW), .ROW_W(RowW), .ROWS(28)) u_dut28 (
        .clk(clk), .rst(rst),
        .din_valid(din_valid[0]), .din_ready(din_ready[0]), .din_row(din_row[0]),
        .pair_valid(pair_valid[0]), .pair_ready(pair_ready[0]), .pair_data(pair_data[0]),
        .lane_en(lane_en[0]), .pair_last(pair_last[0]), .frame_done(frame_done[0])
    );

    pool_line_pair_buffer #(.PIX_W(PixW), .ROW_W(RowW), .ROWS(5)) u_dut5 (
        .clk(clk), .rst(rst),
        .din_valid(din_valid[1]), .din_ready(din_ready[1]), .din_row(din_row[1]),
        .pair_valid(pair_valid[1]), .pair_ready(pair_ready[1]), .pair_data(pair_data[1]),
        .lane_en(lane_en[1]), .pair_last(pair_last[1]), .frame_done(frame_done[1])
    );

    function automatic logic [RowBits-1:0] fill(input logic [15:0] v);
        logic [RowBits-1:0] r;
        for (int j = 0; j < RowW; j++) r[j*PixW +: PixW] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int k, input int lo, input int hi, input bit last);
        exp_t e;
        e.lo = 16'(lo);
        e.hi = 16'(hi);
        e.last = last;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    task automatic send_row(input int k, input int v);
        bit ok = 1'b0;
        din_valid[k] = 1'b1;
        din_row[k]   = fill(16'(v));
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            ok = din_ready[k];
            @(posedge clk);
            #1;
            if (ok) break;
        end
        din_valid[k] = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    // Expected pairs of a full 28-row map whose pixel value equals the row index.
    task automatic frame28();
        for (int p = 0; p < 14; p++) push_exp(0, 2 * p, 2 * p + 1, p == 13);
        for (int r = 0; r < 28; r++) send_row(0, r);
    endtask

    // Monitor: lane_en / frame_done every cycle, pair contents on every consume.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            logic [2*RowBits-1:0] want;
            if (rst) begin
                prev_done[k] = 1'b0;
                continue;
            end
            n_checks++;
            if (lane_en[k] !== {Lanes{pair_valid[k]}}) begin
                n_fail++;
                $display("FAIL lane_en[%0d]: got %h expected %h", k, lane_en[k],
                         {Lanes{pair_valid[k]}});
            end
            n_checks++;
            if (frame_done[k] !== prev_done[k]) begin
                n_fail++;
                $display("FAIL frame_done[%0d]: got %b expected %b", k, frame_done[k],
                         prev_done[k]);
            end
            if (frame_done[k] === 1'b1) done_cnt[k]++;
            prev_done[k] = pair_valid[k] & pair_ready[k] & pair_last[k];
            if (pair_valid[k] === 1'b1 && pair_ready[k] === 1'b1) begin
                n_checks++;
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    n_fail++;
                    $display("FAIL unexpected_pair[%0d]: got lo=%0d hi=%0d expected none", k,
                             pair_data[k][15:0], pair_data[k][RowBits +: 16]);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    want = {fill(e.hi), fill(e.lo)};
                    if (pair_data[k] !== want || pair_last[k] !== e.last) begin
                        n_fail++;
                        $display("FAIL pair[%0d]: got lo=%0d hi=%0d last=%b expected lo=%0d hi=%0d last=%b",
                                 k, pair_data[k][15:0], pair_data[k][RowBits +: 16], pair_last[k],
                                 e.lo, e.hi, e.last);
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1 pair_ready[0] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2*RowBits-1:0] hold;
        bit seen;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            din_valid[k] = 1'b0;
            din_row[k]   = '0;
            pair_ready[k] = 1'b1;
            done_cnt[k]  = 0;
            prev_done[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_pair_valid", 64'(pair_valid[k]), 64'd0);
            chk("rst_lane_en", 64'(lane_en[k]), 64'd0);
            chk("rst_pair_last", 64'(pair_last[k]), 64'd0);
            chk("rst_frame_done", 64'(frame_done[k]), 64'd0);
            chk("rst_pair_data", 64'(|pair_data[k]), 64'd0);
            chk("rst_din_ready", 64'(din_ready[k]), 64'd1);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-frame: pair {5,4} sits stalled in the slot and must be discarded.
        push_exp(0, 0, 1, 1'b0);
        push_exp(0, 2, 3, 1'b0);
        for (int r = 0; r < 5; r++) send_row(0, r);
        pair_ready[0] = 1'b0;
        send_row(0, 5);
        din_valid[0] = 1'b1;
        din_row[0]   = fill(16'd12);
        @(negedge clk);
        chk("stall_din_ready", 64'(din_ready[0]), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_pair_valid", 64'(pair_valid[0]), 64'd0);
        chk("midrst_lane_en", 64'(lane_en[0]), 64'd0);
        chk("midrst_din_ready", 64'(din_ready[0]), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        din_valid[0] = 1'b0;
        pair_ready[0] = 1'b1;

        // Full-rate stream; first row after reset must count as row 0.
        frame28();

        // Back-pressure on the first pair of a map.
        pair_ready[0] = 1'b0;
        fork
            frame28();
            begin
                seen = 1'b0;
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (pair_valid[0] === 1'b1) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("bp_first_pair", 64'(seen), 64'd1);
                hold = pair_data[0];
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("bp_din_ready", 64'(din_ready[0]), 64'd0);
                    chk("bp_data_stable", 64'(pair_data[0] === hold), 64'd1);
                end
                @(posedge clk);
                #1 pair_ready[0] = 1'b1;
            end
        join

        // Two maps back to back with no idle cycle between them.
        frame28();
        frame28();

        // Random pool-side stalls.
        rand_ready_en = 1'b1;
        frame28();
        rand_ready_en = 1'b0;
        repeat (2) @(posedge clk);
        #2 pair_ready[0] = 1'b1;

        // Odd map height: last row is paired with itself, twice in a row.
        for (int f = 0; f < 2; f++) begin
            push_exp(1, 0, 1, 1'b0);
            push_exp(1, 2, 3, 1'b0);
            push_exp(1, 4, 4, 1'b1);
            for (int r = 0; r < 5; r++) send_row(1, r);
        end

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("frame_done_cnt0", 64'(done_cnt[0]), 64'd5);
        chk("frame_done_cnt1", 64'(done_cnt[1]), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
